// File: rtl/multiword_signed_adder_pkg.sv
// rtl/multiword_signed_adder_pkg.sv - shared encodings and helpers for the multi-cycle signed adder
//
// Purpose: FSM state encoding, add/sub operation encodings and the
//          saturation-constant helper used by multiword_signed_adder.
package multiword_signed_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the saturation helper can describe; callers cast down to their width.
  localparam int SAT_MAX_W = 128;

  // neg=1 -> most negative value (1000..0), neg=0 -> most positive value (0111..1),
  // both for a two's-complement number of the given width.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width) begin
        v[i] = (i == width - 1) ? neg : ~neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/carry_look_adder.sv
// rtl/carry_look_adder.sv - combinational chunk adder exposing its per-bit carry vector
//
// Purpose: adds two WIDTH-bit chunks plus a carry-in using generate/propagate terms.
// Ports:
//   i_a, i_b  in  WIDTH  addends
//   i_cin     in  1      carry into bit 0
//   o_sum     out WIDTH  sum bits
//   o_carry   out WIDTH+1  o_carry[i] is the carry into bit i; o_carry[WIDTH] is carry-out
module carry_look_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH:0]   o_carry
);

  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_prop;

  assign w_gen  = i_a & i_b;
  assign w_prop = i_a ^ i_b;

  // The running carry is a procedural temporary so the vector is never read back
  // inside its own block.
  always_comb begin
    logic v_c;
    v_c        = i_cin;
    o_carry    = '0;
    o_sum      = '0;
    o_carry[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i]     = w_prop[i] ^ v_c;
      v_c          = w_gen[i] | (w_prop[i] & v_c);
      o_carry[i+1] = v_c;
    end
  end

endmodule

// File: rtl/multiword_signed_adder.sv
// rtl/multiword_signed_adder.sv - multi-cycle chunked signed add/subtract with optional saturation
//
// Purpose: adds/subtracts WIDTH-bit signed operands CHUNK bits per clock, carrying
//          between chunks through a register, and reports NZCV flags.
// Ports:
//   clk       in  1      rising-edge clock
//   reset_n   in  1      asynchronous active-low reset
//   start     in  1      request, sampled only while idle
//   x, y      in  WIDTH  signed operands, sampled with start
//   add_sub   in  1      0 = x+y, 1 = x-y, sampled with start
//   saturate  in  1      clamp result on overflow, sampled with start
//   busy      out 1      high while an operation is in progress
//   done      out 1      one-cycle pulse when s and flags update
//   s         out WIDTH  registered result, held between operations
//   overflow, negative, zero, cout  out 1  registered flags, held between operations
module multiword_signed_adder
  import multiword_signed_adder_pkg::*;
#(
  parameter int  CHUNK    = 8,
  parameter int  N_CHUNKS = 4,
  localparam int WIDTH    = CHUNK * N_CHUNKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_sub,
  input  logic             saturate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             cout
);

  localparam int IDXW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_c;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;       // already inverted for subtraction
  logic             r_sat;
  logic [WIDTH-1:0] r_work;    // chunk sums accumulated during RUN
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_overflow;
  logic             r_negative;
  logic             r_zero;
  logic             r_cout;

  logic [CHUNK-1:0] w_xa;
  logic [CHUNK-1:0] w_yb;
  logic [CHUNK-1:0] w_sum;
  logic [CHUNK:0]   w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sat_val;
  logic [WIDTH-1:0] w_res;
  logic             w_unused_bits;

  assign w_last = (r_idx == IDXW'(N_CHUNKS - 1));

  // Select the current chunk of each operand.
  always_comb begin
    w_xa = '0;
    w_yb = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_xa = r_x[i*CHUNK +: CHUNK];
        w_yb = r_y[i*CHUNK +: CHUNK];
      end
    end
  end

  carry_look_adder #(.WIDTH(CHUNK)) u_cla (
    .i_a     (w_xa),
    .i_b     (w_yb),
    .i_cin   (r_c),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Full result on the last chunk: lower chunks from the working register,
  // top chunk straight from the adder.
  always_comb begin
    w_raw                   = r_work;
    w_raw[WIDTH-1 -: CHUNK] = w_sum;
  end

  // The last chunk's MSB is the operand MSB, so its carry-in/out give signed overflow.
  assign w_ovf     = w_carry[CHUNK] ^ w_carry[CHUNK-1];
  assign w_sat_val = WIDTH'(sat_value(WIDTH, r_x[WIDTH-1]));
  assign w_res     = (r_sat && w_ovf) ? w_sat_val : w_raw;

  // Top working chunk is never read back and the low carries are only needed for the sum.
  assign w_unused_bits = ^{w_carry[CHUNK-2:0], r_work[WIDTH-1 -: CHUNK]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_c        <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_sat      <= 1'b0;
      r_work     <= '0;
      r_done     <= 1'b0;
      r_s        <= '0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
      r_zero     <= 1'b1;
      r_cout     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_x   <= x;
          r_y   <= y ^ {WIDTH{add_sub}};
          r_sat <= saturate;
          r_c   <= (add_sub == OP_SUB);  // +1 completes the two's-complement negate
          r_idx <= '0;
        end
      end else begin
        for (int i = 0; i < N_CHUNKS; i++) begin
          if (r_idx == IDXW'(i)) begin
            r_work[i*CHUNK +: CHUNK] <= w_sum;
          end
        end
        if (w_last) begin
          r_s        <= w_res;
          r_overflow <= w_ovf;
          r_cout     <= w_carry[CHUNK];
          r_negative <= w_res[WIDTH-1];
          r_zero     <= (w_res == '0);
          r_done     <= 1'b1;
          r_idx      <= '0;
          r_c        <= 1'b0;
        end else begin
          r_c   <= w_carry[CHUNK];
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign s        = r_s;
  assign overflow = r_overflow;
  assign negative = r_negative;
  assign zero     = r_zero;
  assign cout     = r_cout;

endmodule

// File: tb/tb_multiword_signed_adder.sv
// tb/tb_multiword_signed_adder.sv - self-checking bench for multiword_signed_adder
module tb_multiword_signed_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        v;
    logic        n;
    logic        z;
    logic        c;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        add_sub;
  logic        saturate;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        overflow;
  logic        negative;
  logic        zero;
  logic        cout;

  int   tests_run;
  int   tests_failed;
  exp_t q[$];

  multiword_signed_adder #(.CHUNK(8), .N_CHUNKS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .x        (x),
    .y        (y),
    .add_sub  (add_sub),
    .saturate (saturate),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [31:0] rs, input logic v, input logic c);
    exp_t e;
    e.s = rs;
    e.v = v;
    e.n = rs[31];
    e.z = (rs == 32'h0);
    e.c = c;
    return e;
  endfunction

  // Reference: full-width 33-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic sat);
    logic [31:0] bb;
    logic [32:0] f;
    logic [31:0] raw;
    logic        v;
    bb  = sub ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb} + {32'h0, sub};
    raw = f[31:0];
    v   = (a[31] == bb[31]) && (raw[31] != a[31]);
    if (sat && v) raw = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return make_exp(raw, v, f[32]);
  endfunction

  // Called at a falling edge; returns one falling edge later with start deasserted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic sat, input exp_t e);
    x        = a;
    y        = b;
    add_sub  = sub;
    saturate = sat;
    start    = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency in falling edges since issue, then
  // pops the scoreboard and compares result and flags.
  task automatic wait_check(input string tag, input int elapsed);
    int   cyc;
    exp_t e;
    cyc = elapsed;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 64'(done), 64'(1));
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(5));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    if (q.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'(q.size()), 64'(1));
      return;
    end
    e = q.pop_front();
    check({tag, "_s"}, 64'(s), 64'(e.s));
    check({tag, "_vnzc"}, 64'({overflow, negative, zero, cout}), 64'({e.v, e.n, e.z, e.c}));
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int          ndone;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rsub;
    logic        rsat;

    tests_run    = 0;
    tests_failed = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    x        = '0;
    y        = '0;
    add_sub  = 1'b0;
    saturate = 1'b0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy_done", 64'({busy, done}), 64'(0));
    check("reset_s", 64'(s), 64'(0));
    check("reset_vnzc", 64'({overflow, negative, zero, cout}), 64'(4'b0010));

    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, make_exp(32'h0000_0100, 1'b0, 1'b0));
    check("busy_in_run", 64'(busy), 64'(1));
    wait_check("add_ff_1", 1);
    @(negedge clk);

    issue(32'h5, 32'h5, 1'b1, 1'b0, make_exp(32'h0, 1'b0, 1'b1));
    wait_check("sub_5_5", 1);
    @(negedge clk);
    issue(32'h3, 32'h5, 1'b1, 1'b0, make_exp(32'hFFFF_FFFE, 1'b0, 1'b0));
    wait_check("sub_3_5", 1);
    @(negedge clk);

    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, make_exp(32'h8000_0000, 1'b1, 1'b0));
    wait_check("add_ovf_nosat", 1);
    @(negedge clk);
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, make_exp(32'h7FFF_FFFF, 1'b1, 1'b0));
    wait_check("add_ovf_sat", 1);
    @(negedge clk);

    issue(32'h8000_0000, 32'h1, 1'b1, 1'b1, make_exp(32'h8000_0000, 1'b1, 1'b1));
    wait_check("sub_ovf_sat", 1);
    @(negedge clk);
    issue(32'h8000_0000, 32'h1, 1'b1, 1'b0, make_exp(32'h7FFF_FFFF, 1'b1, 1'b1));
    wait_check("sub_ovf_nosat", 1);
    @(negedge clk);

    // start pulsed mid-operation must be ignored
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, make_exp(32'h2345_6789, 1'b0, 1'b0));
    @(negedge clk);
    x     = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_check("start_in_run", 3);
    // back-to-back: start while done is high
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, make_exp(32'h0, 1'b0, 1'b1));
    wait_check("back_to_back", 1);
    count_dones(8, ndone);
    check("no_extra_done", 64'(ndone), 64'(0));

    // reset asserted in the second RUN cycle aborts the operation
    issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, make_exp(32'h0000_1234, 1'b0, 1'b0));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy_done", 64'({busy, done}), 64'(0));
    check("abort_s", 64'(s), 64'(0));
    check("abort_zero", 64'(zero), 64'(1));
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    count_dones(8, ndone);
    check("abort_no_done", 64'(ndone), 64'(0));
    issue(32'h1, 32'h2, 1'b0, 1'b0, make_exp(32'h3, 1'b0, 1'b0));
    wait_check("after_reset_add", 1);
    @(negedge clk);

    // randomized operations against the 33-bit reference
    for (int k = 0; k < 8; k++) begin
      ra   = $urandom();
      rb   = $urandom();
      rsub = 1'($urandom_range(0, 1));
      rsat = 1'($urandom_range(0, 1));
      if (k == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; rsub = 1'b0; rsat = 1'b1; end
      issue(ra, rb, rsub, rsat, model(ra, rb, rsub, rsat));
      wait_check($sformatf("rand%0d", k), 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multiword_signed_adder.md
# multiword_signed_adder

Multi-cycle signed add/subtract unit for operands wider than one adder stage. It processes `CHUNK` bits per clock over `N_CHUNKS` cycles, chaining the carry through a register, with an optional saturating mode. It sits beside the single-cycle signed adder in the ALU datapath and serves wide (e.g. 32/64-bit) operations without a long combinational carry chain. It reports NZCV flags with the same meaning as the combinational adder.

## Interface
- `CHUNK`, default 8: bits added per cycle; must be ≥ 2.
- `N_CHUNKS`, default 4: chunks per operand; must be ≥ 1. Derived `WIDTH = CHUNK*N_CHUNKS`.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `x`, `y`  in  WIDTH  signed two's-complement operands; sampled with `start`.
- `add_sub`  in  1  0 = x+y, 1 = x−y; sampled with `start`.
- `saturate`  in  1  1 = clamp on overflow; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result and flags update.
- `s`  out  WIDTH  registered result; held between operations.
- `overflow`, `negative`, `zero`, `cout`  out  1 each  registered flags; held between operations.

## Operation
- States: IDLE and RUN. Chunk index `idx` counts 0..N_CHUNKS−1. Carry register `c`.
- IDLE with `start`=1: latch `x`, `y ^ {WIDTH{add_sub}}`, `add_sub` and `saturate`. Set `c = add_sub` and `idx = 0`. Go to RUN.
- RUN, each cycle:
  - Chunk sum = x[idx] + y'[idx] + c, written into internal working register chunk `idx`.
  - `c` ← chunk carry-out; `idx` increments.
- RUN, last chunk (`idx = N_CHUNKS−1`):
  - Raw result = working register lower chunks concatenated with the current chunk sum.
  - `cout` = carry out of bit WIDTH−1.
  - `overflow` = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - If `saturate` and `overflow`: `s` = x[WIDTH−1] ? 1000…0 : 0111…1. Otherwise `s` = raw result.
  - `negative` = s[WIDTH−1] and `zero` = (s == 0), both taken after saturation.
  - `overflow` and `cout` always report the raw, unsaturated values.
  - Register all outputs, pulse `done`, return to IDLE.
- Subtraction carry convention: `cout`=1 means no borrow.
- `start` during RUN is ignored; there is no queueing.
- `s` and the flags change only on the `done` edge. They are never partially updated during RUN.

## Timing
- `start` sampled at edge E0 → `busy` high from E0 through E0+N_CHUNKS → `done`, `s` and flags valid after edge E0+N_CHUNKS. Latency N_CHUNKS cycles; `N_CHUNKS`=1 gives 1 cycle.
- `busy` is decoded from state (RUN). `done` is a registered one-cycle pulse.
- Back-to-back: `start` high in the cycle `done` is high is accepted (state is IDLE). Throughput is one operation per N_CHUNKS cycles.
- Reset values: state IDLE, `idx`=0, `c`=0, `busy`=0, `done`=0, `s`=0, `overflow`=`negative`=`cout`=0, `zero`=1 (consistent with `s`=0).
- `reset_n` asserted mid-RUN: immediately returns to the reset values above. The aborted operation produces no `done`. The first `start` after deassertion behaves normally.

## Structure
- Shared ALU package: state encoding (IDLE, RUN); `ADD`/`SUB` encodings of `add_sub`; a function returning the saturation constants for a given width.
- One sub-module: `carry_look_adder #(.WIDTH(CHUNK))` as the per-chunk adder. Its per-bit carry vector provides the MSB carry-in/carry-out for the overflow flag.
- `idx` width is $clog2(N_CHUNKS), minimum 1 bit.

## Test plan
All cases use CHUNK=8, N_CHUNKS=4.
- add 0x000000FF + 0x00000001 → after 4 cycles `s`=0x00000100, N=0 Z=0 C=0 V=0. Checks cross-chunk carry.
- sub 0x00000005 − 0x00000005 → `s`=0, Z=1 C=1 V=0 N=0. Then sub 3−5 → `s`=0xFFFFFFFE, N=1 C=0.
- add 0x7FFFFFFF + 1 with saturate=0 → `s`=0x80000000, V=1 N=1. Same with saturate=1 → `s`=0x7FFFFFFF, V=1 N=0 C=0.
- sub 0x80000000 − 1 with saturate=1 → `s`=0x80000000, V=1 N=1 C=1. With saturate=0 → `s`=0x7FFFFFFF.
- `start` pulsed during RUN is ignored: a single `done` 4 cycles after the original start. `start` in the `done` cycle → a second `done` exactly 4 cycles later with the correct result.
- `reset_n` low at cycle 2 of RUN → `busy`=0, `s`=0, `zero`=1 immediately, no `done`. A following add 1+2 → `s`=3.
